tdm_demux8: RTL
===============

# tdm_demux8

Eight-channel time-division demultiplexer: the receive-side counterpart of the team's 8:1 select mux. It accepts a serialised sample stream with a frame-sync marker and distributes consecutive samples to eight registered output channels. An internal 3-bit slot counter replaces the external select lines, and a two-state lock machine detects and recovers from frame misalignment. It sits between a serial link or shared bus and eight per-channel consumers.

## Interface
- W, 1, sample width in bits per channel (W >= 1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  W  incoming sample
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  qualified by din_valid; marks the sample for slot 0
- dout  output  8*W  channel i occupies bits [i*W +: W]
- ch_valid  output  8  per-channel one-cycle update strobe
- sel  output  3  slot index the next valid sample will be written to
- frame_done  output  1  one-cycle pulse when slot 7 is written
- sync_err  output  1  one-cycle pulse on a detected misalignment
- locked  output  1  high while in RUN

## Operation
- Reset values: dout=0, ch_valid=0, sel=0, frame_done=0, sync_err=0, locked=0, state HUNT.
- Cycles with din_valid=0: all state held; ch_valid, frame_done and sync_err are 0. frame_sync is ignored.
- HUNT:
  - din_valid=1, frame_sync=0: sample dropped.
  - din_valid=1, frame_sync=1: write channel 0, sel<=1, go to RUN.
- RUN, din_valid=1:
  - frame_sync=1, sel=0: normal start. Write channel 0, sel<=1.
  - frame_sync=1, sel!=0 (early sync): sync_err pulse, partial frame abandoned, write channel 0, sel<=1, stay in RUN.
  - frame_sync=0, sel=0 (missing sync): sync_err pulse, sample dropped, go to HUNT, locked<=0.
  - frame_sync=0, sel in 1..7: write channel sel, sel<=sel+1. Wrap 7->0 is 3-bit modulo and raises a frame_done pulse.
- A write updates only dout[sel*W +: W]. Other channels hold. ch_valid is one-hot at bit sel.
- At most one of frame_done and sync_err is high in any cycle.

## Timing
- All outputs are registered. A sample accepted on edge N appears on dout, with its ch_valid bit, after edge N. Latency is 1 cycle.
- frame_done is coincident with the channel 7 update. sync_err is coincident with the triggering sample's edge.
- Back-to-back valid samples are sustained at 1 sample per clock. There are no stall outputs.
- Reset asserted mid-frame immediately forces the reset values, regardless of clk. The first valid sample after deassertion is processed under HUNT rules.

## Configuration
- FRAME_LATCH_EN defined:
  - Samples go to an internal 8*W shadow register.
  - dout updates all eight channels together on the frame_done edge. ch_valid=8'hFF for that cycle and 0 otherwise.
  - Frames abandoned by early or missing sync never reach dout; dout keeps the last complete frame.
  - Latency from the slot 7 sample is 1 cycle. Slots 0-6 appear when the frame completes.
- FRAME_LATCH_EN undefined: per-slot update as described in Operation. No shadow register.

## Test plan
- Reset, then with W=1 send sync+1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'b01001101 after 8th edge; frame_done high exactly on that edge; locked=1; sync_err never high.
- In HUNT, send 5 valid samples without frame_sync -> dout=0, ch_valid=0, locked=0; then a synced sample 1 -> dout[0]=1, sel=1, locked=1.
- Mid-frame at sel=4, assert frame_sync with din=1 -> sync_err pulse, dout[0]=1, sel=1; with FRAME_LATCH_EN, dout unchanged from the previous full frame.
- After a full frame, send valid with frame_sync=0 -> sync_err pulse, locked=0, sample dropped, dout unchanged.
- W=4, frames with din_valid gaps of 0-3 random cycles, values 4'h0..4'h7 -> dout=32'h76543210 at each frame_done; sel holds during gaps.
- Assert rst asynchronously at sel=5 -> all outputs 0 before the next clk edge; the next synced frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8
// Description : Eight-channel time-division demultiplexer. A 3-bit slot
//               counter steps through the channels one valid sample at a time.
//               A HUNT/RUN lock machine aligns the counter to frame_sync and
//               recovers from early or missing sync markers.
//               Optional macro FRAME_LATCH_EN: samples are collected in a
//               shadow register, and dout updates all eight channels together
//               when the frame completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [8*W-1:0] dout,
    output logic [7:0]     ch_valid,
    output logic [2:0]     sel,
    output logic           frame_done,
    output logic           sync_err,
    output logic           locked
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [2:0]     r_sel;
    logic [2:0]     w_sel_next;
    logic [8*W-1:0] r_dout;
    logic [7:0]     r_ch_valid;
    logic           r_frame_done;
    logic           r_sync_err;

    logic           w_wr;
    logic [2:0]     w_slot;
    logic           w_done;
    logic           w_err;

    // Lock machine and slot counter: decide the next state and whether/where this sample is written
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_wr         = 1'b0;
        w_slot       = 3'd0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_wr         = 1'b1;
                        w_slot       = 3'd0;
                        w_sel_next   = 3'd1;
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // Early sync abandons the partial frame and restarts at slot 0
                        w_err      = (r_sel != 3'd0);
                        w_wr       = 1'b1;
                        w_slot     = 3'd0;
                        w_sel_next = 3'd1;
                    end else if (r_sel == 3'd0) begin
                        // A frame start without its marker means alignment is lost
                        w_err        = 1'b1;
                        w_state_next = HUNT;
                    end else begin
                        w_wr       = 1'b1;
                        w_slot     = r_sel;
                        w_sel_next = r_sel + 3'd1;
                        w_done     = (r_sel == 3'd7);
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    // State register, slot counter and event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HUNT;
            r_sel        <= 3'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sel        <= w_sel_next;
            r_frame_done <= w_done;
            r_sync_err   <= w_err;
        end
    end

`ifdef FRAME_LATCH_EN
    logic [8*W-1:0] r_shadow;
    logic [8*W-1:0] w_shadow_next;

    // Shadow frame including the sample being written this cycle
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_wr) begin
            w_shadow_next[int'(w_slot)*W +: W] = din;
        end
    end

    // Collect samples privately; publish the whole frame only when slot 7 lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow   <= '0;
            r_dout     <= '0;
            r_ch_valid <= 8'd0;
        end else begin
            r_shadow   <= w_shadow_next;
            r_ch_valid <= w_done ? 8'hFF : 8'h00;
            if (w_done) begin
                r_dout <= w_shadow_next;
            end
        end
    end
`else
    // Per-slot update: only the addressed channel changes, strobed one-hot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= '0;
            r_ch_valid <= 8'd0;
        end else begin
            r_ch_valid <= w_wr ? (8'd1 << w_slot) : 8'd0;
            if (w_wr) begin
                r_dout[int'(w_slot)*W +: W] <= din;
            end
        end
    end
`endif

    assign dout       = r_dout;
    assign ch_valid   = r_ch_valid;
    assign sel        = r_sel;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign locked     = (r_state == RUN);

endmodule
`default_nettype wire
